// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, branch redirect,
// multi-cycle mul/div and data-memory wait states, plus a saturating stall counter.
module hazard_controller #(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_op,
  input  logic             md_done,
  input  logic             mem_dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MDC_W = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_MAX_CYCLES - 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MD_WAIT  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic mem_wait, rs1_hit, rs2_hit, load_use, in_md, md_exit;

  assign mem_wait = mem_dmem_req && !dmem_ack;
  assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
  assign in_md    = (state_q == ST_MD_WAIT);
  assign md_exit  = md_done || (md_cnt_q == MD_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    md_start     = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    timeout_d    = timeout_q;

    if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      if (!in_md) state_d = ST_MEM_WAIT;
    end else if (in_md && !md_exit) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
      md_cnt_d     = md_cnt_q + MDC_W'(1);
    end else begin
      // RUN rules; also the MEM_WAIT ack cycle and the MD_WAIT exit cycle.
      state_d = ST_RUN;
      if (in_md && !md_done) timeout_d = 1'b1;
      if (!in_md && ex_md_op) begin
        md_start     = 1'b1;
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = ST_MD_WAIT;
        md_cnt_d     = '0;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      md_start     = 1'b0;
    end
  end

  assign stall_cnt_d = (pc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign md_timeout   = timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: expectations are queued per step and
// compared against the combinational outputs mid-cycle.
module tb_hazard_controller;

  localparam int CNT_W = 4;

  // {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, ex_mem, mem_wb flush, md_start}
  localparam logic [8:0] C_NONE = 9'b0000_0000_0;
  localparam logic [8:0] C_LU   = 9'b1100_0100_0;
  localparam logic [8:0] C_BR   = 9'b0000_1100_0;
  localparam logic [8:0] C_MDI  = 9'b1110_0010_1;
  localparam logic [8:0] C_MDH  = 9'b1110_0010_0;
  localparam logic [8:0] C_MEMW = 9'b1111_0001_0;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic ex_md_op, md_done, mem_dmem_req, dmem_ack;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start, md_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0] obs_ctl;

  typedef struct {
    string            tag;
    logic [8:0]       ctl;
    logic             tmo;
    logic [CNT_W-1:0] cnt;
    bit               regs;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic exp_tmo = 1'b0;

  always #5 clk = ~clk;

  hazard_controller #(.MD_MAX_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_md_op(ex_md_op), .md_done(md_done),
    .mem_dmem_req(mem_dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .md_start(md_start),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  assign obs_ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start};

  task automatic idle();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_md_op = 1'b0; md_done = 1'b0;
    mem_dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step(input string tag, input logic [8:0] ctl, input bit regs);
    exp_t e;
    sb_q.push_back('{tag: tag, ctl: ctl, tmo: exp_tmo, cnt: exp_cnt, regs: regs});
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (obs_ctl === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
    end
    if (e.regs) begin
      checks++;
      assert (stall_cycles === e.cnt) else begin
        failures++;
        $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, stall_cycles, e.cnt);
      end
      checks++;
      assert (md_timeout === e.tmo) else begin
        failures++;
        $error("FAIL %s md_timeout observed=%b expected=%b", e.tag, md_timeout, e.tmo);
      end
    end
    if (ctl[8] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("rst_gate", C_NONE, 1'b0);
    exp_cnt = '0;
    exp_tmo = 1'b0;
    step("rst_regs", C_NONE, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    ex_md_op = 1'b1; mem_dmem_req = 1'b1; ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_used = 1'b1; id_rs1_addr = 5'd5;
    do_reset();
    idle();
    step("idle", C_NONE, 1'b1);

    // Load-use on rs1, then the bubble clears it.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_used = 1'b1; id_rs1_addr = 5'd5;
    step("lu_rs1", C_LU, 1'b1);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    step("lu_clear", C_NONE, 1'b1);

    // rs2 match, unused operand, non-writing load.
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = 5'd7;
    id_rs1_used = 1'b1; id_rs1_addr = 5'd3; id_rs2_used = 1'b1; id_rs2_addr = 5'd7;
    step("lu_rs2", C_LU, 1'b1);
    id_rs2_used = 1'b0;
    step("lu_unused", C_NONE, 1'b1);
    id_rs2_used = 1'b1; ex_reg_write = 1'b0;
    step("lu_nowrite", C_NONE, 1'b1);

    // Load to x0.
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b1; id_rs1_addr = 5'd0; id_rs2_used = 1'b1; id_rs2_addr = 5'd0;
    step("lu_x0", C_NONE, 1'b1);

    // Branch overrides load-use.
    ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; ex_branch_taken = 1'b1;
    step("br_lu", C_BR, 1'b1);
    idle();
    step("br_after", C_NONE, 1'b1);

    // Mul/div: issue, 4 hold cycles, done.
    do_reset();
    idle();
    ex_md_op = 1'b1;
    step("md_issue", C_MDI, 1'b1);
    for (int i = 0; i < 4; i++) step("md_hold", C_MDH, 1'b1);
    md_done = 1'b1;
    step("md_done", C_NONE, 1'b1);
    md_done = 1'b0; ex_md_op = 1'b0;
    step("md_run", C_NONE, 1'b1);
    md_done = 1'b1;
    step("md_done_in_run", C_NONE, 1'b1);
    md_done = 1'b0;

    // Branch evaluated on the MD exit cycle.
    ex_md_op = 1'b1;
    step("md2_issue", C_MDI, 1'b1);
    step("md2_hold", C_MDH, 1'b1);
    md_done = 1'b1; ex_branch_taken = 1'b1;
    step("md_exit_br", C_BR, 1'b1);
    idle();

    // Memory wait during MD_WAIT keeps the MD state.
    ex_md_op = 1'b1;
    step("md3_issue", C_MDI, 1'b1);
    mem_dmem_req = 1'b1;
    step("md_memw", C_MEMW, 1'b1);
    step("md_memw", C_MEMW, 1'b1);
    mem_dmem_req = 1'b0;
    step("md_after_memw", C_MDH, 1'b1);
    md_done = 1'b1;
    step("md3_done", C_NONE, 1'b1);
    idle();

    // Memory wait in RUN delays the mul/div start until the ack.
    do_reset();
    idle();
    mem_dmem_req = 1'b1; ex_md_op = 1'b1;
    for (int i = 0; i < 3; i++) step("memw", C_MEMW, 1'b1);
    dmem_ack = 1'b1;
    step("memw_ack_issue", C_MDI, 1'b1);
    mem_dmem_req = 1'b0; dmem_ack = 1'b0; md_done = 1'b1;
    step("memw_md_done", C_NONE, 1'b1);
    idle();
    step("memw_cnt", C_NONE, 1'b1);

    // Watchdog: 8 cycles in MD_WAIT without md_done.
    do_reset();
    idle();
    ex_md_op = 1'b1;
    step("wd_issue", C_MDI, 1'b1);
    for (int i = 0; i < 7; i++) step("wd_hold", C_MDH, 1'b1);
    step("wd_exit", C_NONE, 1'b1);
    exp_tmo = 1'b1;
    ex_md_op = 1'b0;
    step("wd_flag", C_NONE, 1'b1);
    ex_md_op = 1'b1;
    step("wd2_issue", C_MDI, 1'b1);
    md_done = 1'b1;
    step("wd2_done", C_NONE, 1'b1);
    idle();
    step("wd_sticky", C_NONE, 1'b1);

    // Reset in the middle of MD_WAIT returns to RUN.
    ex_md_op = 1'b1;
    step("mid_issue", C_MDI, 1'b1);
    step("mid_hold", C_MDH, 1'b1);
    do_reset();
    step("rst_md_reissue", C_MDI, 1'b1);
    md_done = 1'b1;
    step("rst_md_done", C_NONE, 1'b1);
    idle();

    // stall_cycles saturates at all ones.
    do_reset();
    idle();
    mem_dmem_req = 1'b1;
    for (int i = 0; i < 20; i++) step("sat_memw", C_MEMW, 1'b1);
    dmem_ack = 1'b1;
    step("sat_ack", C_NONE, 1'b1);
    idle();
    step("sat_cnt", C_NONE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
